// File: rtl/regfile_write_ctrl_if.sv
// Write-request / storage-drive / hazard-query bundle for regfile_write_ctrl.
// The master side issues requests and queries; the slave side is the controller.
interface regfile_write_ctrl_if #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 5
);
    logic                req_valid;
    logic                req_ready;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_data;
    logic [NUM_REGS-1:0] we_onehot;
    logic [DATA_W-1:0]   wr_data;
    logic [ADDR_W-1:0]   qry_addr;
    logic                qry_hit;
    logic                busy;
    logic                err_addr;

    modport master (
        output req_valid, req_addr, req_data, qry_addr,
        input  req_ready, we_onehot, wr_data, qry_hit, busy, err_addr
    );

    modport slave (
        input  req_valid, req_addr, req_data, qry_addr,
        output req_ready, we_onehot, wr_data, qry_hit, busy, err_addr
    );
endinterface

// File: rtl/regfile_write_ctrl.sv
// Register-file write-port controller: queues write requests, drains one per cycle into a
// registered one-hot write-enable plus data bus, and answers "write to X still in flight?".
module regfile_write_ctrl #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ZERO_REG = 31
) (
    input logic            clk,
    input logic            reset,
    regfile_write_ctrl_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]   mem_addr_q [DEPTH];
    logic [ADDR_W-1:0]   mem_addr_d [DEPTH];
    logic [DATA_W-1:0]   mem_data_q [DEPTH];
    logic [DATA_W-1:0]   mem_data_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [NUM_REGS-1:0] we_onehot_q, we_onehot_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                err_addr_q, err_addr_d;

    logic              in_range;
    logic              push_acc;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [ADDR_W-1:0] zero_addr;

    assign zero_addr     = ADDR_W'(ZERO_REG);
    assign bus.req_ready = (count_q < CNT_W'(DEPTH));
    assign in_range      = (32'(bus.req_addr) < NUM_REGS);
    assign push_acc      = bus.req_valid && bus.req_ready;
    // Out-of-range requests complete the handshake but never enter the queue.
    assign push          = push_acc && in_range;
    assign pop           = (count_q != '0);
    assign head_addr     = mem_addr_q[rd_ptr_q];

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        we_onehot_d = '0;
        wr_data_d   = wr_data_q;
        err_addr_d  = err_addr_q | (push_acc && !in_range);

        if (push) begin
            mem_addr_d[wr_ptr_q] = bus.req_addr;
            mem_data_d[wr_ptr_q] = bus.req_data;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            wr_data_d = mem_data_q[rd_ptr_q];
            if (head_addr != zero_addr) begin
                we_onehot_d = NUM_REGS'(1) << head_addr;
            end
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Entry i is live when its distance from the read pointer is below count.
    always_comb begin
        logic             hit;
        logic [PTR_W-1:0] offset;
        hit    = 1'b0;
        offset = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr_q;
            if ((CNT_W'(offset) < count_q) && (mem_addr_q[i] == bus.qry_addr)) begin
                hit = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (we_onehot_q[i] && (32'(bus.qry_addr) == i)) begin
                hit = 1'b1;
            end
        end
        bus.qry_hit = hit && (bus.qry_addr != zero_addr);
    end

    assign bus.we_onehot = we_onehot_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.err_addr  = err_addr_q;
    assign bus.busy      = (count_q != '0) || (|we_onehot_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_addr_q[i] <= '0;
                mem_data_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            we_onehot_q <= '0;
            wr_data_q   <= '0;
            err_addr_q  <= 1'b0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            we_onehot_q <= we_onehot_d;
            wr_data_q   <= wr_data_d;
            err_addr_q  <= err_addr_d;
        end
    end
endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Bench for regfile_write_ctrl: directed scenarios plus random traffic, every cycle compared
// against a queue-based model of the request FIFO and output stage.
module tb_regfile_write_ctrl;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned ZERO_REG = 31;

    logic clk;
    logic reset;

    regfile_write_ctrl_if #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bif ();

    regfile_write_ctrl #(
        .NUM_REGS(NUM_REGS),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .ZERO_REG(ZERO_REG)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned     a;
        logic [63:0]     d;
    } ent_t;

    ent_t        mq[$];
    bit          m_out_v;
    int unsigned m_out_a;
    logic [63:0] m_data;
    bit          m_err;

    int n_cmp;
    int n_bad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_hit(input int unsigned qa);
        bit h;
        h = m_out_v && (m_out_a == qa);
        foreach (mq[i]) if (mq[i].a == qa) h = 1'b1;
        return h && (qa != ZERO_REG);
    endfunction

    function automatic logic [63:0] m_we();
        return m_out_v ? (64'd1 << m_out_a) : 64'd0;
    endfunction

    // One clock: drive, check combinational outputs, advance model, check registered outputs.
    task automatic step(input bit v, input int unsigned a, input logic [63:0] d,
                        input int unsigned qa, input bit rst);
        bit   acc;
        ent_t e;
        bif.req_valid = v;
        bif.req_addr  = ADDR_W'(a);
        bif.req_data  = d;
        bif.qry_addr  = ADDR_W'(qa);
        reset         = rst;
        #1;
        check("req_ready", 64'(bif.req_ready), 64'(mq.size() < DEPTH));
        check("qry_hit", 64'(bif.qry_hit), 64'(m_hit(qa)));
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_out_v = 1'b0;
            m_data  = '0;
            m_err   = 1'b0;
        end else begin
            acc = v && (mq.size() < DEPTH);
            if (mq.size() != 0) begin
                e       = mq.pop_front();
                m_data  = e.d;
                m_out_v = (e.a != ZERO_REG);
                m_out_a = e.a;
            end else begin
                m_out_v = 1'b0;
            end
            if (acc) begin
                if (a < NUM_REGS) mq.push_back('{a: a, d: d});
                else m_err = 1'b1;
            end
        end
        #1;
        check("we_onehot", 64'(bif.we_onehot), m_we());
        check("wr_data", bif.wr_data, m_data);
        check("busy", 64'(bif.busy), 64'((mq.size() != 0) || m_out_v));
        check("err_addr", 64'(bif.err_addr), 64'(m_err));
    endtask

    task automatic idle(input int unsigned qa);
        step(1'b0, 0, 64'd0, qa, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        bif.req_valid = 1'b0;
        bif.req_addr  = '0;
        bif.req_data  = '0;
        bif.qry_addr  = '0;
        reset         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        m_out_v = 1'b0;
        m_out_a = 0;
        m_data  = '0;
        m_err   = 1'b0;
        check("rst_we", 64'(bif.we_onehot), 64'd0);
        check("rst_data", bif.wr_data, 64'd0);
        check("rst_busy", 64'(bif.busy), 64'd0);
        check("rst_err", 64'(bif.err_addr), 64'd0);
        check("rst_ready", 64'(bif.req_ready), 64'd1);

        // Single write: enable visible exactly one cycle, one cycle after acceptance.
        step(1'b1, 3, 64'hA5, 3, 1'b0);
        check("t1_we_early", 64'(bif.we_onehot), 64'd0);
        idle(3);
        check("t1_we", 64'(bif.we_onehot), 64'h8);
        check("t1_data", bif.wr_data, 64'hA5);
        idle(3);
        check("t1_we_off", 64'(bif.we_onehot), 64'd0);
        check("t1_busy", 64'(bif.busy), 64'd0);

        // Burst of five, in order.
        for (int i = 0; i < 5; i++) step(1'b1, i, 64'(100 + i), i, 1'b0);
        repeat (3) idle(4);

        // Zero register: accepted, never enabled, never a hazard.
        step(1'b1, ZERO_REG, 64'hFF, ZERO_REG, 1'b0);
        repeat (3) idle(ZERO_REG);
        check("t3_data", bif.wr_data, 64'hFF);

        // Out-of-range address sets sticky error; later writes still work.
        step(1'b1, 40, 64'h1234, 40, 1'b0);
        check("t4_err", 64'(bif.err_addr), 64'd1);
        step(1'b1, 5, 64'h55, 5, 1'b0);
        idle(5);
        check("t4_we", 64'(bif.we_onehot), 64'h20);
        repeat (2) idle(5);
        check("t4_err_sticky", 64'(bif.err_addr), 64'd1);

        // Same-register hazard tracking.
        step(1'b1, 7, 64'h71, 7, 1'b0);
        step(1'b1, 7, 64'h72, 7, 1'b0);
        step(1'b1, 9, 64'h91, 7, 1'b0);
        repeat (4) idle(7);

        // Reset with writes in flight.
        for (int i = 0; i < 3; i++) step(1'b1, 10 + i, 64'(200 + i), 11, 1'b0);
        step(1'b0, 0, 64'd0, 11, 1'b1);
        check("t6_busy", 64'(bif.busy), 64'd0);
        check("t6_err", 64'(bif.err_addr), 64'd0);
        repeat (3) idle(11);

        // Pointer wrap over ten sequential writes.
        for (int i = 0; i < 10; i++) step(1'b1, 20 + i, 64'(300 + i), 22, 1'b0);
        repeat (3) idle(22);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 2) != 0), $urandom_range(0, 35),
                 {$urandom, $urandom}, $urandom_range(0, 33), ($urandom_range(0, 49) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
